// File: rtl/jk_pkg.sv
// Shared JK definitions: the command encoding of a {j,k} pair and its decoder,
// used by the counter cells and by the property module.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    CLR    = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_e;

  function automatic jk_cmd_e jk_decode(input logic j, input logic k);
    jk_cmd_e cmd;
    case ({j, k})
      2'b10:   cmd = SET;
      2'b01:   cmd = CLR;
      2'b11:   cmd = TOGGLE;
      default: cmd = HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/fv_jk_mod_counter.sv
// Property module bound into jk_mod_counter: per-cell JK behaviour and
// counter-level increment, decrement, boundary, load clamp, priority and tc rules.
module fv_jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH,
  parameter int RST_VAL = 0
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             up,
  input logic             load,
  input logic [WIDTH-1:0] load_val,
  input logic [WIDTH-1:0] q,
  input logic             tc,
  input logic             wrap,
  input logic [WIDTH-1:0] j,
  input logic [WIDTH-1:0] k
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  // Arms the checks only once a reset has been seen, so power-up garbage is ignored.
  logic started;
  always_ff @(posedge clk) begin
    if (rst) started <= 1'b1;
  end

`ifdef JK_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_EDGE_Q = MAX_VAL;
  localparam logic [WIDTH-1:0] DN_EDGE_Q = '0;
`else
  localparam logic [WIDTH-1:0] UP_EDGE_Q = '0;
  localparam logic [WIDTH-1:0] DN_EDGE_Q = MAX_VAL;
`endif

  a_rst: assert property (@(posedge clk)
    $past(rst) |-> (q == RST_Q && !wrap));

  a_load: assert property (@(posedge clk)
    $past(started && !rst && load) |->
      (q == (($past(load_val) > MAX_VAL) ? MAX_VAL : $past(load_val)) && !wrap));

  a_hold: assert property (@(posedge clk)
    $past(started && !rst && !load && !en) |-> (q == $past(q) && !wrap));

  a_inc: assert property (@(posedge clk)
    $past(started && !rst && !load && en && up && q != MAX_VAL) |->
      (q == $past(q) + WIDTH'(1) && !wrap));

  a_dec: assert property (@(posedge clk)
    $past(started && !rst && !load && en && !up && q != '0) |->
      (q == $past(q) - WIDTH'(1) && !wrap));

  a_edge_up: assert property (@(posedge clk)
    $past(started && !rst && !load && en && up && q == MAX_VAL) |->
      (q == UP_EDGE_Q && wrap));

  a_edge_dn: assert property (@(posedge clk)
    $past(started && !rst && !load && en && !up && q == '0) |->
      (q == DN_EDGE_Q && wrap));

  a_tc: assert property (@(posedge clk)
    started |-> (tc == (en && (up ? (q == MAX_VAL) : (q == '0)))));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    a_set: assert property (@(posedge clk)
      $past(started && !rst && jk_decode(j[i], k[i]) == SET) |-> q[i]);
    a_clr: assert property (@(posedge clk)
      $past(started && !rst && jk_decode(j[i], k[i]) == CLR) |-> !q[i]);
    a_tog: assert property (@(posedge clk)
      $past(started && !rst && jk_decode(j[i], k[i]) == TOGGLE) |-> (q[i] != $past(q[i])));
    a_hld: assert property (@(posedge clk)
      $past(started && !rst && jk_decode(j[i], k[i]) == HOLD) |-> (q[i] == $past(q[i])));
  end

endmodule

bind jk_mod_counter fv_jk_mod_counter #(
  .WIDTH  (WIDTH),
  .MODULUS(MODULUS),
  .RST_VAL(RST_VAL)
) u_fv (
  .clk     (clk),
  .rst     (rst),
  .en      (en),
  .up      (up),
  .load    (load),
  .load_val(load_val),
  .q       (q),
  .tc      (tc),
  .wrap    (wrap),
  .j       (j),
  .k       (k)
);

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset to a per-cell value.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      case (jk_decode(j, k))
        SET:     q <= 1'b1;
        CLR:     q <= 1'b0;
        TOGGLE:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from WIDTH JK cells, with load clamping and a wrap pulse.
// Define JK_COUNTER_SATURATE_EN to saturate at the boundary instead of wrapping.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             boundary;
  logic             wrap_nxt;

  assign boundary = up ? (q == MAX_VAL) : (q == '0);
  assign tc       = en & boundary;

  // Bit i toggles once every lower bit is all-ones (up) or all-zeros (down).
  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & (up ? q[i-1] : ~q[i-1]);
    end
  end

  always_comb begin
    nxt      = q;
    j        = '0;
    k        = '0;
    wrap_nxt = 1'b0;
    if (load) begin
      nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      j   = nxt;
      k   = ~nxt;
    end else if (en) begin
      if (boundary) begin
        wrap_nxt = 1'b1;
`ifdef JK_COUNTER_SATURATE_EN
        nxt = q;
`else
        nxt = up ? '0 : MAX_VAL;
        j   = nxt;
        k   = ~nxt;
`endif
      end else begin
        j = t;
        k = t;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RST_Q[i]),
      .j      (j[i]),
      .k      (k[i]),
      .q      (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parametrised synchronous modulo-N up/down counter built from a bank of JK flip-flop cells, one per bit. It generalises the single JK flip-flop to WIDTH bits with enable, parallel load, direction control, programmable modulus and a registered wrap flag. It serves as the standard counting primitive for the flip-flop exercise set and carries its own bound property module.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2 ≤ MODULUS ≤ 2**WIDTH)
- RST_VAL, 0, value loaded on reset (< MODULUS)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value for load
- q  out  WIDTH  current count
- tc  out  1  terminal count (combinational)
- wrap  out  1  registered one-cycle wrap pulse

## Operation
- Priority at each posedge: rst > load > en > hold.
- rst: q ← RST_VAL, wrap ← 0.
- load: q ← load_val; if load_val ≥ MODULUS, q ← MODULUS-1. wrap ← 0. up and en ignored.
- en & up: q ← q+1; if q == MODULUS-1, q ← 0 and wrap ← 1.
- en & !up: q ← q-1; if q == 0, q ← MODULUS-1 and wrap ← 1.
- !en & !load: q holds, wrap ← 0.
- Per-bit JK drive: normal counting uses J=K=T_i (toggle; T_i = AND of lower bits for up, AND of inverted lower bits for down); load and wrap use J=nxt_i, K=~nxt_i; hold uses J=K=0. Each cell obeys JK semantics: 10→set, 01→clear, 11→toggle, 00→hold.
- tc = en & ((up & q == MODULUS-1) | (!up & q == 0)); does not depend on load.
- Arithmetic is modulo MODULUS, never modulo 2**WIDTH, unless they are equal.

## Timing
- Latency: one cycle from inputs sampled at posedge N to q at N+1.
- wrap is asserted for exactly the cycle after the wrapping edge; back-to-back wraps (MODULUS=2, en held) give continuous wrap=1.
- Direction change takes effect on the same edge it is sampled; no pipeline.
- rst asserted mid-count overrides load/en on that edge; counting resumes from RST_VAL on the first edge with rst low.
- load and en together: load wins, no count, no wrap.
- tc is valid combinationally in the same cycle as q; no registered delay.

## Configuration
- JK_COUNTER_SATURATE_EN defined: at the boundary the counter saturates instead of wrapping (up at MODULUS-1 holds; down at 0 holds); wrap is then a one-cycle pulse on each enabled edge attempted at the boundary (saturation hit).
- Not defined: modulo wrap-around as described in Operation.
- Load clamping and tc are identical in both builds.

## Structure
- Package jk_pkg: jk_cmd_e enum (HOLD, SET, CLR, TOGGLE) and a function mapping {j,k} to jk_cmd_e; shared by the RTL and the property module.
- Sub-module jk_cell: single-bit JK flip-flop with clk, rst, rst value, j, k, q; instantiated WIDTH times via generate.
- Property module fv_jk_mod_counter bound to jk_mod_counter: per-bit JK properties plus counter-level properties (increment, decrement, wrap, load, clamp, priority).

## Test plan
- WIDTH=4, MODULUS=10, RST_VAL=0: rst 1 cycle, then en=1 up=1 for 12 cycles → q 1..9,0,1,2; wrap=1 only the cycle after q=9→0; tc=1 while q=9.
- Same, up=0 from q=0 → q=9 next cycle, wrap=1; tc=1 at q=0 with en=1.
- load=1 load_val=13 with en=1 → q=9 next cycle, wrap=0; load_val=5 → q=5.
- q=7 counting up, assert rst alongside load=1 load_val=3 → q=0 next cycle, wrap=0.
- en=0 for 5 cycles at q=4, toggling up → q stays 4, tc=0, wrap=0.
- JK_COUNTER_SATURATE_EN, up from q=8 for 3 enabled cycles → q 9,9,9; wrap=0,1,1.
